pdm_modulator: RTL and testbench

PDM_MODULATOR -- requirements
Module: pdm_modulator

---
 rtl/audio_pkg.sv | 22 ++
 rtl/pdm_modulator_if.sv | 33 +++
 rtl/pdm_clock_edge_detect.sv | 40 ++++
 rtl/pdm_modulator.sv | 188 ++++++++++++++++++
 tb/tb_pdm_modulator.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio blocks.
//   WORD_LENGTH_DEFAULT : default PCM sample width and PDM bits per sample
//   ACC_MID             : mid-scale accumulator value for the default width
//   pdm_mod_state_t     : PDM modulator operating states
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int WORD_LENGTH_DEFAULT = 16;

    // Half of full scale; the accumulator starts here so that a zero PCM
    // sample produces a centred 1,0,1,0 stream from the first bit.
    localparam int ACC_MID = 2 ** (WORD_LENGTH_DEFAULT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } pdm_mod_state_t;

endpackage

// File: rtl/pdm_modulator_if.sv
// -----------------------------------------------------------------------------
// pdm_modulator_if
// PCM sample handshake into the PDM modulator.
//   sample_i       : signed two's-complement PCM sample (producer -> modulator)
//   sample_valid_i : sample_i holds a valid sample    (producer -> modulator)
//   sample_ready_o : modulator holding buffer is empty (modulator -> producer)
// A sample transfers in any cycle where valid and ready are both high.
// -----------------------------------------------------------------------------
interface pdm_modulator_if
    import audio_pkg::*;
#(
    parameter int WORD_LENGTH = WORD_LENGTH_DEFAULT
);

    logic [WORD_LENGTH-1:0] sample_i;
    logic                   sample_valid_i;
    logic                   sample_ready_o;

    // Producer side (e.g. a DMA engine or the testbench).
    modport master (
        output sample_i,
        output sample_valid_i,
        input  sample_ready_o
    );

    // Modulator side.
    modport slave (
        input  sample_i,
        input  sample_valid_i,
        output sample_ready_o
    );

endinterface

// File: rtl/pdm_clock_edge_detect.sv
// -----------------------------------------------------------------------------
// pdm_clock_edge_detect
// Brings the asynchronous PDM bit clock into the system clock domain and
// produces a one-cycle launch strobe on the selected edge.
//   clock_i   : system clock
//   reset_n_i : asynchronous active-low reset
//   pdm_clk_i : asynchronous PDM bit clock
//   lrsel_i   : 1 = strobe on falling edge, 0 = strobe on rising edge
//   strobe_o  : one-cycle launch strobe (combinational from registered state)
// -----------------------------------------------------------------------------
module pdm_clock_edge_detect (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic pdm_clk_i,
    input  logic lrsel_i,
    output logic strobe_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Two synchronizer flops followed by a history flop for edge detection.
    // The strobe is visible after the second edge so that the register it
    // feeds updates on the third clock_i edge after the pdm_clk_i transition.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pdm_clk_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign strobe_o = lrsel_i ? (prev_q & ~sync2_q) : (sync2_q & ~prev_q);

endmodule

// File: rtl/pdm_modulator.sv
// -----------------------------------------------------------------------------
// pdm_modulator
// First-order sigma-delta PDM modulator with a one-entry sample buffer.
//   clock_i      : system clock, all logic on the rising edge
//   reset_n_i    : asynchronous active-low reset
//   enable_i     : 1 = modulate, 0 = idle
//   sample_bus   : PCM sample handshake (slave side)
//   pdm_clk_i    : asynchronous PDM bit clock from the receiver
//   pdm_lrsel_i  : 1 = launch on falling pdm_clk_i edge, 0 = rising edge
//   pdm_data_o   : PDM bitstream
//   done_o       : one-cycle pulse when a sample's bits are fully emitted
//   underrun_o   : one-cycle pulse when a sample boundary finds no new sample
// -----------------------------------------------------------------------------
module pdm_modulator
    import audio_pkg::*;
#(
    parameter int WORD_LENGTH        = WORD_LENGTH_DEFAULT,
    parameter int SYSTEM_FREQUENCY   = 100_000_000,
    parameter int SAMPLING_FREQUENCY = 1_000_000
) (
    input  logic           clock_i,
    input  logic           reset_n_i,
    input  logic           enable_i,
    pdm_modulator_if.slave sample_bus,
    input  logic           pdm_clk_i,
    input  logic           pdm_lrsel_i,
    output logic           pdm_data_o,
    output logic           done_o,
    output logic           underrun_o
);

    localparam int                     CNT_W    = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(WORD_LENGTH - 1);
    localparam logic [WORD_LENGTH-1:0] ACC_INIT = {1'b1, {(WORD_LENGTH-1){1'b0}}};

    // Each pdm_clk_i phase must span the synchronizer plus edge pipeline,
    // so the system clock has to be comfortably faster than the bit clock.
    if (SYSTEM_FREQUENCY < 6 * SAMPLING_FREQUENCY) begin : g_ratio_check
        $error("pdm_modulator: SYSTEM_FREQUENCY too low for SAMPLING_FREQUENCY");
    end

    pdm_mod_state_t         state_q, state_d;
    logic [WORD_LENGTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WORD_LENGTH-1:0] cur_q, cur_d;
    logic [WORD_LENGTH-1:0] buf_q, buf_d;
    logic                   buf_full_q, buf_full_d;
    logic                   data_q, data_d;
    logic                   done_q, done_d;
    logic                   underrun_q, underrun_d;
    logic                   ready_q;

    logic                   strobe;
    logic                   accept;
    logic                   modulate;
    logic                   clear_dp;
    logic                   prime_load;
    logic [WORD_LENGTH:0]   sum;

    pdm_clock_edge_detect u_edge (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .pdm_clk_i (pdm_clk_i),
        .lrsel_i   (pdm_lrsel_i),
        .strobe_o  (strobe)
    );

    assign accept = sample_bus.sample_valid_i & ready_q;
    assign sum    = {1'b0, acc_q} + {1'b0, cur_q};

    // State register.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: PRIME waits for a buffered sample before running;
    // dropping enable from PRIME or RUN always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_i) state_d = PRIME;
            PRIME: begin
                if (!enable_i)       state_d = IDLE;
                else if (buf_full_q) state_d = RUN;
            end
            RUN:     if (!enable_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs. Outside of an enabled RUN the datapath is held at its
    // start values, which also swallows a strobe coinciding with RUN exit.
    always_comb begin
        modulate   = 1'b0;
        prime_load = 1'b0;
        clear_dp   = 1'b1;
        case (state_q)
            PRIME: prime_load = enable_i & buf_full_q;
            RUN: begin
                clear_dp = ~enable_i;
                modulate = enable_i & strobe;
            end
            default: ;
        endcase
    end

    // Datapath next state: accumulate on each strobe, swap in the buffered
    // sample at the word boundary, and capture accepted samples as offset
    // binary (MSB inverted). Accept and load never coincide because ready
    // is low whenever the buffer is full.
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        data_d     = data_q;
        done_d     = 1'b0;
        underrun_d = 1'b0;

        if (clear_dp) begin
            acc_d  = ACC_INIT;
            cnt_d  = '0;
            data_d = 1'b0;
        end else if (modulate) begin
            data_d = sum[WORD_LENGTH];
            acc_d  = sum[WORD_LENGTH-1:0];
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                done_d = 1'b1;
                if (buf_full_q) begin
                    cur_d      = buf_q;
                    buf_full_d = 1'b0;
                end else begin
                    underrun_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (prime_load) begin
            cur_d      = buf_q;
            buf_full_d = 1'b0;
        end

        if (accept) begin
            buf_d      = {~sample_bus.sample_i[WORD_LENGTH-1], sample_bus.sample_i[WORD_LENGTH-2:0]};
            buf_full_d = 1'b1;
        end
    end

    // Datapath registers. Ready tracks the next buffer state so that it
    // always equals "buffer empty" while staying low during reset.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_q      <= ACC_INIT;
            cnt_q      <= '0;
            cur_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            data_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            data_q     <= data_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            ready_q    <= ~buf_full_d;
        end
    end

    assign sample_bus.sample_ready_o = ready_q;
    assign pdm_data_o                = data_q;
    assign done_o                    = done_q;
    assign underrun_o                = underrun_q;

endmodule

// File: tb/tb_pdm_modulator.sv
// -----------------------------------------------------------------------------
// tb_pdm_modulator
// Self-checking bench for pdm_modulator. A behavioural model predicts every
// output each cycle from the modulation rules; directed scenarios add
// hand-computed bit patterns and pulse positions.
// -----------------------------------------------------------------------------
module tb_pdm_modulator;
    import audio_pkg::*;

    localparam int WL   = WORD_LENGTH_DEFAULT;
    localparam int FULL = 2 ** WL;

    typedef struct {
        int data;
        int done;
        int under;
    } strobe_rec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic enable  = 1'b0;
    logic pdm_clk = 1'b0;
    logic lrsel   = 1'b0;
    logic pdm_data;
    logic done;
    logic underrun;

    int checks = 0;
    int errors = 0;

    // Model state
    pdm_mod_state_t mState   = IDLE;
    int             mAcc     = ACC_MID;
    int             mCnt     = 0;
    int             mCur     = 0;
    int             mBuf     = 0;
    bit             mBufFull = 1'b0;
    int             strobeIn = 0;
    bit             mStrobeRun = 1'b0;
    bit             eData  = 1'b0;
    bit             eDone  = 1'b0;
    bit             eUnder = 1'b0;
    bit             eReady = 1'b0;

    strobe_rec_t logQ[$];

    pdm_modulator_if #(.WORD_LENGTH(WL)) sampleBus ();

    pdm_modulator #(
        .WORD_LENGTH        (WL),
        .SYSTEM_FREQUENCY   (100_000_000),
        .SAMPLING_FREQUENCY (1_000_000)
    ) dut (
        .clock_i     (clock),
        .reset_n_i   (reset_n),
        .enable_i    (enable),
        .sample_bus  (sampleBus),
        .pdm_clk_i   (pdm_clk),
        .pdm_lrsel_i (lrsel),
        .pdm_data_o  (pdm_data),
        .done_o      (done),
        .underrun_o  (underrun)
    );

    // System clock: rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    // PDM bit clock: 16 system clocks per period, edges offset from clock edges.
    initial begin
        #3;
        forever #80 pdm_clk = ~pdm_clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int toOffset(input logic [WL-1:0] s);
        return int'($signed(s)) + ACC_MID;
    endfunction

    function automatic strobe_rec_t logAt(input int i);
        strobe_rec_t r;
        r = '{-1, -1, -1};
        if (i < logQ.size()) r = logQ[i];
        return r;
    endfunction

    function automatic int onesIn(input int first, input int count);
        int n = 0;
        for (int i = first; i < first + count; i++) begin
            if (i < logQ.size()) n += logQ[i].data;
        end
        return n;
    endfunction

    // A selected pdm_clk transition becomes a launch three clock edges later.
    always @(pdm_clk) begin
        if (pdm_clk != lrsel) strobeIn = 3;
    end

    // Behavioural model: acc is an integer in [0, FULL), each launch adds the
    // offset sample and emits the carry out of FULL.
    always @(posedge clock) begin
        bit strobe;
        bit accept;
        int sum;
        strobe = 1'b0;
        if (strobeIn > 0) begin
            strobeIn--;
            strobe = (strobeIn == 0);
        end
        mStrobeRun = 1'b0;
        eDone      = 1'b0;
        eUnder     = 1'b0;
        if (!reset_n) begin
            mState   = IDLE;
            mAcc     = ACC_MID;
            mCnt     = 0;
            mBufFull = 1'b0;
            strobeIn = 0;
            eData    = 1'b0;
            eReady   = 1'b0;
        end else begin
            accept = sampleBus.sample_valid_i && eReady;
            case (mState)
                IDLE: begin
                    eData = 1'b0;
                    if (enable) mState = PRIME;
                end
                PRIME: begin
                    eData = 1'b0;
                    if (!enable) begin
                        mState = IDLE;
                    end else if (mBufFull) begin
                        mCur     = mBuf;
                        mBufFull = 1'b0;
                        mState   = RUN;
                    end
                end
                default: begin
                    if (!enable) begin
                        mState = IDLE;
                        mAcc   = ACC_MID;
                        mCnt   = 0;
                        eData  = 1'b0;
                    end else if (strobe) begin
                        sum        = mAcc + mCur;
                        eData      = (sum >= FULL);
                        mAcc       = sum % FULL;
                        mStrobeRun = 1'b1;
                        if (mCnt == WL - 1) begin
                            mCnt  = 0;
                            eDone = 1'b1;
                            if (mBufFull) begin
                                mCur     = mBuf;
                                mBufFull = 1'b0;
                            end else begin
                                eUnder = 1'b1;
                            end
                        end else begin
                            mCnt++;
                        end
                    end
                end
            endcase
            if (accept) begin
                mBuf     = toOffset(sampleBus.sample_i);
                mBufFull = 1'b1;
            end
            eReady = !mBufFull;
        end
    end

    // Records the DUT outputs on every launch the model performs in RUN.
    always @(posedge clock) begin
        #1;
        if (mStrobeRun) logQ.push_back('{int'(pdm_data), int'(done), int'(underrun)});
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        checkOutput("cycle pdm_data_o", int'(pdm_data), int'(eData));
        checkOutput("cycle done_o", int'(done), int'(eDone));
        checkOutput("cycle underrun_o", int'(underrun), int'(eUnder));
        checkOutput("cycle sample_ready_o", int'(sampleBus.sample_ready_o), int'(eReady));
    end

    // Offers one sample and holds valid for exactly the accepting cycle.
    task automatic applyStimulus(input logic [WL-1:0] value);
        int budget = 300;
        bit sent   = 1'b0;
        while (!sent && budget > 0) begin
            @(negedge clock);
            budget--;
            if (sampleBus.sample_ready_o) begin
                sampleBus.sample_i       = value;
                sampleBus.sample_valid_i = 1'b1;
                @(negedge clock);
                sampleBus.sample_valid_i = 1'b0;
                sent = 1'b1;
            end
        end
        checks++;
        if (!sent) begin
            errors++;
            $display("[TB] FAIL handshake_timeout: sample %h not accepted, ready stayed 0", value);
        end
    endtask

    task automatic waitStrobes(input int n);
        int budget = n * 40 + 100;
        while (logQ.size() < n && budget > 0) begin
            @(posedge clock);
            #2;
            budget--;
        end
        checks++;
        if (logQ.size() < n) begin
            errors++;
            $display("[TB] FAIL strobe_timeout: got %0d launches, expected %0d", logQ.size(), n);
        end
    endtask

    task automatic goIdle();
        @(negedge clock);
        enable = 1'b0;
        repeat (6) @(negedge clock);
        logQ.delete();
    endtask

    // Directed scenarios.
    initial begin
        sampleBus.sample_i       = '0;
        sampleBus.sample_valid_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset pdm_data_o", int'(pdm_data), 0);
        checkOutput("reset done_o", int'(done), 0);
        checkOutput("reset underrun_o", int'(underrun), 0);
        checkOutput("reset sample_ready_o", int'(sampleBus.sample_ready_o), 0);
        @(negedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("ready after reset", int'(sampleBus.sample_ready_o), 1);

        // Zero sample, rising-edge launch: 1,0,1,0 with a refill for word 2
        goIdle();
        lrsel = 1'b0;
        applyStimulus(16'h0000);
        enable = 1'b1;
        applyStimulus(16'h0000);
        waitStrobes(32);
        checkOutput("zero bit0", logAt(0).data, 1);
        checkOutput("zero bit1", logAt(1).data, 0);
        checkOutput("zero bit2", logAt(2).data, 1);
        checkOutput("zero bit3", logAt(3).data, 0);
        checkOutput("zero ones word1", onesIn(0, 16), 8);
        checkOutput("zero ones word2", onesIn(16, 16), 8);
        checkOutput("zero done bit14", logAt(14).done, 0);
        checkOutput("zero done bit15", logAt(15).done, 1);
        checkOutput("zero underrun bit15", logAt(15).under, 0);
        checkOutput("zero done bit31", logAt(31).done, 1);
        checkOutput("zero underrun bit31", logAt(31).under, 1);

        // Full-scale positive word then full-scale negative word
        goIdle();
        applyStimulus(16'h7FFF);
        enable = 1'b1;
        applyStimulus(16'h8000);
        waitStrobes(32);
        checkOutput("max ones", onesIn(0, 16), 16);
        checkOutput("min ones", onesIn(16, 16), 0);

        // 0x4000: 1,1,0,1 pattern, no refill so the word repeats after underrun
        goIdle();
        applyStimulus(16'h4000);
        enable = 1'b1;
        waitStrobes(32);
        checkOutput("q bit0", logAt(0).data, 1);
        checkOutput("q bit1", logAt(1).data, 1);
        checkOutput("q bit2", logAt(2).data, 0);
        checkOutput("q bit3", logAt(3).data, 1);
        checkOutput("q ones word1", onesIn(0, 16), 12);
        checkOutput("q underrun bit15", logAt(15).under, 1);
        checkOutput("q done bit15", logAt(15).done, 1);
        checkOutput("q repeat bit16", logAt(16).data, 1);
        checkOutput("q repeat bit18", logAt(18).data, 0);
        checkOutput("q ones word2", onesIn(16, 16), 12);

        // Falling-edge launch
        goIdle();
        lrsel = 1'b1;
        repeat (4) @(negedge clock);
        applyStimulus(16'h0000);
        enable = 1'b1;
        waitStrobes(16);
        checkOutput("fall bit0", logAt(0).data, 1);
        checkOutput("fall bit1", logAt(1).data, 0);
        checkOutput("fall ones", onesIn(0, 16), 8);

        // Reset mid-word with a sample waiting in the buffer
        goIdle();
        lrsel = 1'b0;
        repeat (4) @(negedge clock);
        applyStimulus(16'h4000);
        enable = 1'b1;
        applyStimulus(16'h1234);
        waitStrobes(5);
        @(negedge clock);
        #1 reset_n = 1'b0;
        enable = 1'b0;
        #1;
        checkOutput("midreset pdm_data_o", int'(pdm_data), 0);
        checkOutput("midreset done_o", int'(done), 0);
        checkOutput("midreset underrun_o", int'(underrun), 0);
        checkOutput("midreset sample_ready_o", int'(sampleBus.sample_ready_o), 0);
        repeat (3) @(negedge clock);
        logQ.delete();
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("ready after midreset", int'(sampleBus.sample_ready_o), 1);
        applyStimulus(16'h0000);
        enable = 1'b1;
        waitStrobes(2);
        checkOutput("restart bit0", logAt(0).data, 1);
        checkOutput("restart bit1", logAt(1).data, 0);

        goIdle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench always ends on its own.
    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
